// File: rtl/mul_pkg.sv
// Shared definitions for the integer multiplier issue path: op encoding,
// tag widths and op-class decode helpers.
package mul_pkg;

    localparam int MUL_LAT             = 3;
    localparam int LG_ROB_ENTRIES      = 6;
    localparam int LG_PRF_ENTRIES      = 6;
    localparam int LG_HILO_PRF_ENTRIES = 2;

    typedef enum logic [2:0] {
        MUL   = 3'd0,
        MULT  = 3'd1,
        MULTU = 3'd2,
        MADD  = 3'd3,
        MADDU = 3'd4,
        MSUB  = 3'd5,
        MSUBU = 3'd6
    } mul_op_t;

    function automatic logic op_unsigned(input mul_op_t op);
        return (op == MULTU) || (op == MADDU) || (op == MSUBU);
    endfunction

    // Every op except MUL (GPR destination) writes the HI/LO pair.
    function automatic logic op_writes_hilo(input mul_op_t op);
        return (op == MULT) || (op == MULTU) || (op == MADD) ||
               (op == MADDU) || (op == MSUB) || (op == MSUBU);
    endfunction

    function automatic logic op_is_acc(input mul_op_t op);
        return (op == MADD) || (op == MADDU) || (op == MSUB) || (op == MSUBU);
    endfunction

endpackage

// File: rtl/mul_sched_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the port that wins a
// tie and moves to the loser after every grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic rr;

    always_comb begin
        gnt = '0;
        if (req[rr])
            gnt[rr] = 1'b1;
        else if (req[~rr])
            gnt[~rr] = 1'b1;
    end

    // Granting port 0 hands priority to port 1 and vice versa.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rr <= 1'b0;
        else if (|gnt)
            rr <= gnt[0];
    end

endmodule

// File: rtl/mul_sched.sv
// Multiplier issue scheduler: arbitrates two request ports, blocks accumulate
// ops behind in-flight HI/LO writers and gates completions of flushed ops.
module mul_sched
    import mul_pkg::*;
#(
    parameter int LAT = MUL_LAT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [1:0]                     req_valid,
    output logic [1:0]                     req_ready,
    input  mul_op_t                        req_op       [2],
    input  logic [31:0]                    req_src_a    [2],
    input  logic [31:0]                    req_src_b    [2],
    input  logic [63:0]                    req_src_hilo [2],
    input  logic [LG_ROB_ENTRIES-1:0]      req_rob_ptr  [2],
    input  logic [LG_PRF_ENTRIES-1:0]      req_gpr_ptr  [2],
    input  logic [LG_HILO_PRF_ENTRIES-1:0] req_hilo_ptr [2],
    input  logic                           flush,
    output logic                           mul_go,
    output logic                           mul_unsigned,
    output logic                           mul_is_mul,
    output logic                           mul_is_madd,
    output logic                           mul_is_msub,
    output logic [31:0]                    mul_src_a,
    output logic [31:0]                    mul_src_b,
    output logic [63:0]                    mul_src_hilo,
    output logic [LG_ROB_ENTRIES-1:0]      mul_rob_ptr,
    output logic [LG_PRF_ENTRIES-1:0]      mul_gpr_ptr,
    output logic [LG_HILO_PRF_ENTRIES-1:0] mul_hilo_ptr,
    input  logic                           mul_complete,
    input  logic [LG_ROB_ENTRIES-1:0]      mul_rob_ptr_out,
    output logic                           wb_complete,
    output logic [$clog2(LAT+2)-1:0]       inflight_cnt
);

    localparam int CNT_W = $clog2(LAT+2);

    logic [LAT:0]              v;
    logic [LAT:0]              hilo_w;
    logic [LG_ROB_ENTRIES-1:0] rob [LAT+1];

    logic       hilo_busy;
    logic [1:0] elig;
    logic [1:0] gnt;
    logic       sel;
    mul_op_t    op_g;

    assign hilo_busy = |(v & hilo_w);

    // Reset and flush both close the issue window combinationally.
    always_comb begin
        for (int i = 0; i < 2; i++)
            elig[i] = req_valid[i] & ~flush & reset &
                      ~(op_is_acc(req_op[i]) & hilo_busy);
    end

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (elig),
        .gnt   (gnt)
    );

    assign req_ready = gnt;
    assign mul_go    = |gnt;
    assign sel       = gnt[1];
    assign op_g      = req_op[sel];

    always_comb begin
        mul_unsigned = mul_go & op_unsigned(op_g);
        mul_is_mul   = mul_go & (op_g == MUL);
        mul_is_madd  = mul_go & ((op_g == MADD) | (op_g == MADDU));
        mul_is_msub  = mul_go & ((op_g == MSUB) | (op_g == MSUBU));
        mul_src_a    = mul_go ? req_src_a[sel]    : '0;
        mul_src_b    = mul_go ? req_src_b[sel]    : '0;
        mul_src_hilo = mul_go ? req_src_hilo[sel] : '0;
        mul_rob_ptr  = mul_go ? req_rob_ptr[sel]  : '0;
        mul_gpr_ptr  = mul_go ? req_gpr_ptr[sel]  : '0;
        mul_hilo_ptr = mul_go ? req_hilo_ptr[sel] : '0;
    end

    // Shadow pipeline: stage k holds the op issued k+1 cycles ago.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v      <= '0;
            hilo_w <= '0;
            for (int k = 0; k <= LAT; k++)
                rob[k] <= '0;
        end else begin
            v      <= flush ? '0 : {v[LAT-1:0], mul_go};
            hilo_w <= {hilo_w[LAT-1:0], mul_go & op_writes_hilo(op_g)};
            rob[0] <= mul_rob_ptr;
            for (int k = 1; k <= LAT; k++)
                rob[k] <= rob[k-1];
        end
    end

    assign wb_complete = mul_complete & v[LAT];

    always_comb begin
        inflight_cnt = '0;
        for (int k = 0; k <= LAT; k++)
            inflight_cnt = inflight_cnt + CNT_W'(v[k]);
    end

`ifndef SYNTHESIS
    // A live final stage must line up with the multiplier's own completion.
    assert property (@(posedge clk) disable iff (!reset)
        v[LAT] |-> (mul_complete && (mul_rob_ptr_out == rob[LAT])));
`endif

endmodule

// File: tb/tb_mul_sched.sv
// Bench for mul_sched: event-list reference model of accepted ops, a delay-line
// multiplier stand-in, directed scenarios with literal pins, then random traffic.
module tb_mul_sched;
    import mul_pkg::*;

    localparam int LAT = 3;
    localparam int RW  = LG_ROB_ENTRIES;
    localparam int GW  = LG_PRF_ENTRIES;
    localparam int HW  = LG_HILO_PRF_ENTRIES;
    localparam int CW  = $clog2(LAT+2);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    req_valid = '0;
    logic [1:0]    req_ready;
    mul_op_t       req_op       [2];
    logic [31:0]   req_src_a    [2];
    logic [31:0]   req_src_b    [2];
    logic [63:0]   req_src_hilo [2];
    logic [RW-1:0] req_rob_ptr  [2];
    logic [GW-1:0] req_gpr_ptr  [2];
    logic [HW-1:0] req_hilo_ptr [2];
    logic          flush = 1'b0;
    logic          mul_go, mul_unsigned, mul_is_mul, mul_is_madd, mul_is_msub;
    logic [31:0]   mul_src_a, mul_src_b;
    logic [63:0]   mul_src_hilo;
    logic [RW-1:0] mul_rob_ptr;
    logic [GW-1:0] mul_gpr_ptr;
    logic [HW-1:0] mul_hilo_ptr;
    logic          mul_complete = 1'b0;
    logic [RW-1:0] mul_rob_ptr_out = '0;
    logic          wb_complete;
    logic [CW-1:0] inflight_cnt;

    mul_sched #(.LAT(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_src_a(req_src_a), .req_src_b(req_src_b),
        .req_src_hilo(req_src_hilo), .req_rob_ptr(req_rob_ptr),
        .req_gpr_ptr(req_gpr_ptr), .req_hilo_ptr(req_hilo_ptr), .flush(flush),
        .mul_go(mul_go), .mul_unsigned(mul_unsigned), .mul_is_mul(mul_is_mul),
        .mul_is_madd(mul_is_madd), .mul_is_msub(mul_is_msub),
        .mul_src_a(mul_src_a), .mul_src_b(mul_src_b), .mul_src_hilo(mul_src_hilo),
        .mul_rob_ptr(mul_rob_ptr), .mul_gpr_ptr(mul_gpr_ptr),
        .mul_hilo_ptr(mul_hilo_ptr), .mul_complete(mul_complete),
        .mul_rob_ptr_out(mul_rob_ptr_out), .wb_complete(wb_complete),
        .inflight_cnt(inflight_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            c;
        bit            hilo;
        logic [RW-1:0] rob;
        bit            dead;
    } op_rec_t;

    op_rec_t       ops[$];
    int            cyc = 0;
    int            rr_m = 0;
    int            exp_g = -1;
    bit            hold_payload = 0;
    bit            go_hist  [8192];
    logic [RW-1:0] rob_hist [8192];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit is_live(input op_rec_t o, input int t);
        return !o.dead && (o.c <= t - 1) && (o.c >= t - LAT - 1);
    endfunction

    task automatic model_reset();
        foreach (ops[i]) ops[i].dead = 1;
        rr_m = 0;
    endtask

    // Expected outputs for the current cycle from the list of accepted ops.
    task automatic compare();
        bit            hz = 0;
        bit            wb_e = 0;
        int            cnt = 0;
        bit [1:0]      el;
        int            g;
        logic [3:0]    ctrl_e = '0;
        logic [141:0]  pay_e = '0;
        foreach (ops[i]) begin
            if (is_live(ops[i], cyc)) begin
                cnt++;
                if (ops[i].hilo) hz = 1;
                if (ops[i].c == cyc - LAT - 1) wb_e = 1;
            end
        end
        for (int i = 0; i < 2; i++)
            el[i] = reset && !flush && req_valid[i] &&
                    !((req_op[i] inside {MADD, MADDU, MSUB, MSUBU}) && hz);
        if (el[rr_m])          g = rr_m;
        else if (el[1 - rr_m]) g = 1 - rr_m;
        else                   g = -1;
        exp_g = g;
        if (g >= 0) begin
            ctrl_e = {req_op[g] inside {MULTU, MADDU, MSUBU}, req_op[g] == MUL,
                      req_op[g] inside {MADD, MADDU}, req_op[g] inside {MSUB, MSUBU}};
            pay_e  = {req_src_a[g], req_src_b[g], req_src_hilo[g],
                      req_rob_ptr[g], req_gpr_ptr[g], req_hilo_ptr[g]};
        end
        chk("req_ready", req_ready, (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10));
        chk("mul_go", mul_go, g >= 0);
        chk("ctrl", {mul_unsigned, mul_is_mul, mul_is_madd, mul_is_msub}, ctrl_e);
        chk("payload", {mul_src_a, mul_src_b, mul_src_hilo, mul_rob_ptr,
                        mul_gpr_ptr, mul_hilo_ptr}, pay_e);
        chk("wb_complete", wb_complete, wb_e & mul_complete);
        chk("inflight_cnt", inflight_cnt, cnt);
    endtask

    task automatic drive(input bit [1:0] vld, input mul_op_t o0, input mul_op_t o1,
                         input bit fl, input bit rs,
                         input logic [RW-1:0] r0, input logic [RW-1:0] r1);
        int k;
        @(negedge clk);
        if (!rs && reset) model_reset();
        reset     = rs;
        req_valid = vld;
        req_op[0] = o0;
        req_op[1] = o1;
        flush     = fl;
        req_rob_ptr[0] = r0;
        req_rob_ptr[1] = r1;
        if (!hold_payload) begin
            for (int i = 0; i < 2; i++) begin
                req_src_a[i]    = $urandom;
                req_src_b[i]    = $urandom;
                req_src_hilo[i] = {$urandom, $urandom};
                req_gpr_ptr[i]  = GW'($urandom);
                req_hilo_ptr[i] = HW'($urandom);
            end
        end
        k = cyc - LAT - 1;
        mul_complete    = (k >= 0) ? go_hist[k] : 1'b0;
        mul_rob_ptr_out = (k >= 0) ? rob_hist[k] : '0;
        #2;
        compare();
    endtask

    task automatic tick();
        op_rec_t n;
        go_hist[cyc]  = mul_go;
        rob_hist[cyc] = mul_rob_ptr;
        @(posedge clk);
        if (reset) begin
            if (flush) foreach (ops[i]) ops[i].dead = 1;
            if (exp_g >= 0) begin
                n.c    = cyc;
                n.hilo = (req_op[exp_g] != MUL);
                n.rob  = req_rob_ptr[exp_g];
                n.dead = 0;
                ops.push_back(n);
                rr_m = 1 - exp_g;
            end
        end
        while (ops.size() > 0 && ops[0].c < cyc - LAT - 2) void'(ops.pop_front());
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(2'b00, MUL, MUL, 1'b0, 1'b1, '0, '0);
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_op[i] = MUL; req_src_a[i] = '0; req_src_b[i] = '0; req_src_hilo[i] = '0;
            req_rob_ptr[i] = '0; req_gpr_ptr[i] = '0; req_hilo_ptr[i] = '0;
        end

        // Reset held: everything quiet even with requests pending.
        drive(2'b11, MULT, MUL, 1'b0, 1'b0, 6'd1, 6'd2);
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_go", mul_go, 1'b0);
        chk("rst_inflight", inflight_cnt, 0);
        tick();
        drive(2'b00, MUL, MUL, 1'b0, 1'b0, '0, '0);
        tick();
        idle(2);

        // Signed MULT on port 0, completion LAT+1 cycles later.
        req_src_a[0] = 32'd3;
        req_src_b[0] = 32'hFFFF_FFFE;
        hold_payload = 1;
        drive(2'b01, MULT, MUL, 1'b0, 1'b1, 6'd5, 6'd0);
        hold_payload = 0;
        chk("t1_go", mul_go, 1'b1);
        chk("t1_unsigned", mul_unsigned, 1'b0);
        chk("t1_src_b", mul_src_b, 32'hFFFF_FFFE);
        tick();
        idle(3);
        drive(2'b00, MUL, MUL, 1'b0, 1'b1, '0, '0);
        chk("t1_wb", wb_complete, 1'b1);
        chk("t1_tag", mul_rob_ptr_out, 6'd5);
        tick();
        idle(1);

        // MUL does not write HI/LO, so MADD right behind it issues.
        drive(2'b01, MUL, MADD, 1'b0, 1'b1, 6'd7, 6'd8);
        tick();
        drive(2'b10, MUL, MADD, 1'b0, 1'b1, 6'd7, 6'd8);
        chk("t4_ready", req_ready, 2'b10);
        chk("t4_madd", mul_is_madd, 1'b1);
        tick();
        idle(5);

        // MULT then MADD: accumulate waits until the MULT leaves the shadow.
        drive(2'b01, MULT, MADD, 1'b0, 1'b1, 6'd9, 6'd10);
        tick();
        for (int k = 1; k <= 4; k++) begin
            drive(2'b10, MULT, MADD, 1'b0, 1'b1, 6'd9, 6'd10);
            chk("t3_blocked", req_ready, 2'b00);
            tick();
        end
        drive(2'b10, MULT, MADD, 1'b0, 1'b1, 6'd9, 6'd10);
        chk("t3_accept", req_ready, 2'b10);
        tick();
        idle(5);

        // Both ports streaming: alternate grants, pipeline fills to LAT+1.
        for (int k = 0; k < 8; k++) begin
            drive(2'b11, MULTU, MULTU, 1'b0, 1'b1, RW'(k), RW'(k + 20));
            chk("t2_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("t2_inflight", inflight_cnt, (k < 4) ? k : 4);
            tick();
        end
        idle(5);

        // Flush kills two in-flight ops; multiplier still pulses completion.
        drive(2'b01, MULT, MUL, 1'b0, 1'b1, 6'd11, 6'd0);
        tick();
        drive(2'b01, MULT, MUL, 1'b0, 1'b1, 6'd12, 6'd0);
        tick();
        drive(2'b01, MULT, MUL, 1'b1, 1'b1, 6'd13, 6'd0);
        chk("t5_ready", req_ready, 2'b00);
        tick();
        drive(2'b00, MUL, MUL, 1'b0, 1'b1, '0, '0);
        chk("t5_inflight", inflight_cnt, 0);
        tick();
        for (int k = 4; k <= 5; k++) begin
            drive(2'b00, MUL, MUL, 1'b0, 1'b1, '0, '0);
            chk("t5_mul_complete", mul_complete, 1'b1);
            chk("t5_wb", wb_complete, 1'b0);
            tick();
        end
        idle(2);

        // Mid-cycle async reset with two ops in flight and pointer at port 1.
        drive(2'b01, MULT, MULT, 1'b0, 1'b1, 6'd14, 6'd15);
        tick();
        drive(2'b01, MULT, MULT, 1'b0, 1'b1, 6'd16, 6'd17);
        tick();
        drive(2'b00, MUL, MUL, 1'b0, 1'b1, '0, '0);
        chk("t6_inflight_pre", inflight_cnt, 2);
        #1 reset = 1'b0;
        model_reset();
        #1;
        compare();
        chk("t6_inflight_rst", inflight_cnt, 0);
        chk("t6_go_rst", mul_go, 1'b0);
        tick();
        drive(2'b00, MUL, MUL, 1'b0, 1'b0, '0, '0);
        tick();
        drive(2'b11, MULT, MULT, 1'b0, 1'b1, 6'd18, 6'd19);
        chk("t6_ready_port0", req_ready, 2'b01);
        chk("t6_wb_stale", wb_complete, 1'b0);
        tick();
        drive(2'b00, MUL, MUL, 1'b0, 1'b1, '0, '0);
        chk("t6_wb_stale2", wb_complete, 1'b0);
        tick();
        idle(6);

        // Random traffic with occasional flushes and reset pulses.
        for (int n = 0; n < 1500; n++) begin
            drive(2'($urandom), mul_op_t'($urandom_range(0, 6)),
                  mul_op_t'($urandom_range(0, 6)),
                  $urandom_range(0, 19) == 0, $urandom_range(0, 249) != 0,
                  RW'($urandom), RW'($urandom));
            tick();
        end
        idle(LAT + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
